// File: rtl/sr_latch_driver_if.sv
// Signal bundle between the pushbutton/latch side and the S/R/E command driver.
// The master drives the raw buttons and latch feedback. The slave (the driver) returns latch commands and status.
interface sr_latch_driver_if;
    logic btn_S;
    logic btn_R;
    logic Q_fb;
    logic S;
    logic R;
    logic E;
    logic busy;
    logic done;
    logic mismatch;
    logic err;

    modport master (
        output btn_S, btn_R, Q_fb,
        input  S, R, E, busy, done, mismatch, err
    );

    modport slave (
        input  btn_S, btn_R, Q_fb,
        output S, R, E, busy, done, mismatch, err
    );
endinterface

// File: rtl/sr_latch_driver.sv
// Pushbutton front end for an enabled SR latch: two-flop synchronise, debounce, arbitrate,
// then sequence S/R around a bounded E window and verify Q afterwards.
module sr_latch_driver #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_CYCLES    = 2,
    parameter int CNT_W           = 8
) (
    input  logic               clk,
    input  logic               rst,
    sr_latch_driver_if.slave   bus
);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] P_LAST   = CNT_W'(PULSE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ENABLE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_CHECK  = 3'd4
    } state_t;

    // Bit 0 carries the set button, bit 1 the reset button.
    logic [1:0]            btn_s;
    logic [1:0]            sync1_q, sync2_q;
    logic [1:0]            deb_q, deb_d;
    logic [1:0]            debp_q;
    logic [1:0]            req_q, req_d;
    logic [1:0][CNT_W-1:0] cnt_q, cnt_d;

    state_t                state_q, state_d;
    logic                  cmd_set_q, cmd_set_d;
    logic [CNT_W-1:0]      pcnt_q, pcnt_d;
    logic                  s_q, s_d, r_q, r_d, e_q, e_d, busy_q, busy_d;
    logic                  done_q, done_d, mismatch_q, mismatch_d, err_q, err_d;

    assign btn_s = {bus.btn_R, bus.btn_S};

    // Debounce counters and request edge detection for both buttons.
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    deb_d[i] = sync2_q[i];
                    cnt_d[i] = CNT_ZERO;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end else begin
                cnt_d[i] = CNT_ZERO;
            end
        end
        req_d = deb_q & ~debp_q;
    end

    // Command sequencer next state and registered output values.
    always_comb begin
        state_d    = state_q;
        cmd_set_d  = cmd_set_q;
        pcnt_d     = pcnt_q;
        done_d     = 1'b0;
        mismatch_d = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_q[0] && req_q[1]) begin
                    err_d = 1'b1;
                end else if (req_q[0]) begin
                    state_d   = ST_SETUP;
                    cmd_set_d = 1'b1;
                end else if (req_q[1]) begin
                    state_d   = ST_SETUP;
                    cmd_set_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_d = ST_ENABLE;
                pcnt_d  = CNT_ZERO;
            end
            ST_ENABLE: begin
                if (pcnt_q == P_LAST) begin
                    state_d = ST_HOLD;
                    pcnt_d  = CNT_ZERO;
                end else begin
                    pcnt_d = pcnt_q + CNT_ONE;
                end
            end
            ST_HOLD: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                // Q_fb is sampled on the edge that leaves CHECK, so the result pulse follows CHECK.
                state_d    = ST_IDLE;
                done_d     = 1'b1;
                mismatch_d = (bus.Q_fb != cmd_set_q);
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        s_d    = (state_d inside {ST_SETUP, ST_ENABLE, ST_HOLD}) && cmd_set_d;
        r_d    = (state_d inside {ST_SETUP, ST_ENABLE, ST_HOLD}) && !cmd_set_d;
        e_d    = (state_d == ST_ENABLE);
        busy_d = (state_d != ST_IDLE);
    end

    // All state and outputs, cleared asynchronously so rst drops E/S/R at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 2'b00;
            sync2_q    <= 2'b00;
            deb_q      <= 2'b00;
            debp_q     <= 2'b00;
            req_q      <= 2'b00;
            cnt_q      <= {2{CNT_ZERO}};
            state_q    <= ST_IDLE;
            cmd_set_q  <= 1'b0;
            pcnt_q     <= CNT_ZERO;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            e_q        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mismatch_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            sync1_q    <= btn_s;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            debp_q     <= deb_q;
            req_q      <= req_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            cmd_set_q  <= cmd_set_d;
            pcnt_q     <= pcnt_d;
            s_q        <= s_d;
            r_q        <= r_d;
            e_q        <= e_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mismatch_q <= mismatch_d;
            err_q      <= err_d;
        end
    end

    assign bus.S        = s_q;
    assign bus.R        = r_q;
    assign bus.E        = e_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.mismatch = mismatch_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: a timeline model of the button-to-command behaviour is compared
// against the DUT on every falling edge, and directed scenarios pin cycle counts to literals.
module tb_sr_latch_driver;
    localparam int DB = 4;
    localparam int P  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    sr_latch_driver_if bus ();

    sr_latch_driver #(.DEBOUNCE_CYCLES(DB), .PULSE_CYCLES(P), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Latch model; force_q0 overrides its Q to emulate a write that did not land.
    logic latch_q  = 1'b0;
    logic force_q0 = 1'b0;
    assign bus.Q_fb = force_q0 ? 1'b0 : latch_q;
    always @(negedge clk) begin
        if (bus.E && bus.S) latch_q <= 1'b1;
        else if (bus.E && bus.R) latch_q <= 1'b0;
    end

    task automatic check(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // A level flips once the last DB synchronised samples (raw taken 2..DB+1 edges ago) all disagree with it.
    function automatic bit all_differ(input logic [DB+1:0] h, input logic v);
        for (int i = 2; i <= DB + 1; i++) begin
            if (h[i] == v) return 1'b0;
        end
        return 1'b1;
    endfunction

    logic [DB+1:0] hs, hr;
    logic m_deb_s, m_debp_s, m_req_s, m_deb_r, m_debp_r, m_req_r;
    bit   m_active, m_set;
    int   m_d;
    logic x_s, x_r, x_e, x_busy, x_done, x_mis, x_err;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            hs = '0; hr = '0;
            m_deb_s = 1'b0; m_debp_s = 1'b0; m_req_s = 1'b0;
            m_deb_r = 1'b0; m_debp_r = 1'b0; m_req_r = 1'b0;
            m_active = 1'b0; m_set = 1'b0; m_d = 0;
            {x_s, x_r, x_e, x_busy, x_done, x_mis, x_err} = 7'b0;
        end else begin
            x_done = 1'b0; x_mis = 1'b0; x_err = 1'b0;
            if (m_active) begin
                if (m_d == P + 2) begin
                    m_active = 1'b0;
                    x_done   = 1'b1;
                    x_mis    = (bus.Q_fb != m_set);
                end else begin
                    m_d++;
                end
            end else if (m_req_s && m_req_r) begin
                x_err = 1'b1;
            end else if (m_req_s || m_req_r) begin
                m_active = 1'b1;
                m_d      = 0;
                m_set    = m_req_s;
            end
            m_req_s = m_deb_s & ~m_debp_s; m_debp_s = m_deb_s;
            m_req_r = m_deb_r & ~m_debp_r; m_debp_r = m_deb_r;
            hs = {hs[DB:0], bus.btn_S};
            hr = {hr[DB:0], bus.btn_R};
            if (all_differ(hs, m_deb_s)) m_deb_s = ~m_deb_s;
            if (all_differ(hr, m_deb_r)) m_deb_r = ~m_deb_r;
            x_busy = m_active;
            x_s    = m_active && m_set && (m_d <= P + 1);
            x_r    = m_active && !m_set && (m_d <= P + 1);
            x_e    = m_active && (m_d >= 1) && (m_d <= P);
        end
    end

    int c_s = 0, c_r = 0, c_e = 0, c_busy = 0, c_done = 0, c_mis = 0, c_err = 0;

    // Every-cycle comparison against the model plus the S/R exclusion invariant, and event counters.
    initial forever begin
        @(negedge clk);
        check("S", bus.S, x_s);
        check("R", bus.R, x_r);
        check("E", bus.E, x_e);
        check("busy", bus.busy, x_busy);
        check("done", bus.done, x_done);
        check("mismatch", bus.mismatch, x_mis);
        check("err", bus.err, x_err);
        check("s_and_r", bus.S & bus.R, 1'b0);
        c_s += int'(bus.S); c_r += int'(bus.R); c_e += int'(bus.E);
        c_busy += int'(bus.busy); c_done += int'(bus.done);
        c_mis += int'(bus.mismatch); c_err += int'(bus.err);
    end

    task automatic clr();
        c_s = 0; c_r = 0; c_e = 0; c_busy = 0; c_done = 0; c_mis = 0; c_err = 0;
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic expect_counts(input string tag, input int s, input int r, input int e,
                                 input int b, input int d, input int m, input int er);
        check_int({tag, "_s_cycles"}, c_s, s);
        check_int({tag, "_r_cycles"}, c_r, r);
        check_int({tag, "_e_cycles"}, c_e, e);
        check_int({tag, "_busy_cycles"}, c_busy, b);
        check_int({tag, "_done_pulses"}, c_done, d);
        check_int({tag, "_mismatch_pulses"}, c_mis, m);
        check_int({tag, "_err_pulses"}, c_err, er);
    endtask

    int  lat;
    bit  seen;

    initial begin
        bus.btn_S = 1'b0;
        bus.btn_R = 1'b0;
        wait_neg(3);
        rst = 1'b0;
        check("reset_S", bus.S, 1'b0);
        check("reset_E", bus.E, 1'b0);
        check("reset_busy", bus.busy, 1'b0);
        wait_neg(2);

        // Clean SET: busy must appear 8 edges after the press (req on edge 7, SETUP on edge 8).
        clr();
        bus.btn_S = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (bus.busy && lat == 0) lat = k;
        end
        check_int("set_latency", lat, 8);
        wait_neg(1);
        bus.btn_S = 1'b0;
        wait_neg(20);
        expect_counts("set", 4, 0, 2, 5, 1, 0, 0);
        check("set_latch_q", latch_q, 1'b1);

        // Clean RST after the SET.
        clr();
        bus.btn_R = 1'b1;
        wait_neg(10);
        bus.btn_R = 1'b0;
        wait_neg(20);
        expect_counts("rst", 0, 4, 2, 5, 1, 0, 0);
        check("rst_latch_q", latch_q, 1'b0);

        // Three-cycle glitch must not get through the debouncer.
        clr();
        bus.btn_S = 1'b1;
        wait_neg(3);
        bus.btn_S = 1'b0;
        wait_neg(20);
        expect_counts("glitch", 0, 0, 0, 0, 0, 0, 0);

        // Simultaneous presses: one err pulse, no command.
        clr();
        bus.btn_S = 1'b1;
        bus.btn_R = 1'b1;
        wait_neg(12);
        bus.btn_S = 1'b0;
        bus.btn_R = 1'b0;
        wait_neg(20);
        expect_counts("both", 0, 0, 0, 0, 0, 0, 1);

        // R request lands while the SET is in ENABLE and must be dropped.
        clr();
        bus.btn_S = 1'b1;
        wait_neg(2);
        bus.btn_R = 1'b1;
        wait_neg(12);
        bus.btn_S = 1'b0;
        bus.btn_R = 1'b0;
        wait_neg(20);
        expect_counts("busy_drop", 4, 0, 2, 5, 1, 0, 0);

        // Latch feedback stuck low during a SET.
        clr();
        force_q0 = 1'b1;
        bus.btn_S = 1'b1;
        wait_neg(10);
        bus.btn_S = 1'b0;
        wait_neg(20);
        force_q0 = 1'b0;
        expect_counts("qfb_bad", 4, 0, 2, 5, 1, 1, 0);

        // Asynchronous reset in the middle of the enable window.
        bus.btn_S = 1'b1;
        seen = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(posedge clk); #1;
            if (bus.E) seen = 1'b1;
        end
        check("enable_reached", seen, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_E", bus.E, 1'b0);
        check("async_rst_S", bus.S, 1'b0);
        check("async_rst_R", bus.R, 1'b0);
        check("async_rst_busy", bus.busy, 1'b0);
        bus.btn_S = 1'b0;
        wait_neg(3);
        rst = 1'b0;
        wait_neg(15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
- Upstream control stage for sr_latch_w_en: turns two raw pushbutton inputs into clean, sequenced S/R/E commands for the latch.
- Synchronises and debounces each button, then arbitrates between them; the forbidden S=R=1 combination is never driven.
- Generates a bounded enable window per command and checks the latch's Q feedback afterwards to confirm the write landed.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required before a debounced level changes (min 1).
- PULSE_CYCLES, 2, number of cycles E is held high per command (min 1).
- CNT_W, 8, width of the debounce and pulse counters; must satisfy 2^CNT_W > max(DEBOUNCE_CYCLES, PULSE_CYCLES).

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- btn_S  in  1  raw, asynchronous "set" button.
- btn_R  in  1  raw, asynchronous "reset" button.
- Q_fb  in  1  Q fed back from the latch.
- S  out  1  set input to the latch.
- R  out  1  reset input to the latch.
- E  out  1  enable input to the latch.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse when a command completes.
- mismatch  out  1  one-cycle pulse, coincident with done, when Q_fb is not the expected value.
- err  out  1  one-cycle pulse when both requests arrive in the same cycle.

Behaviour:
- Reset (asynchronous): all outputs 0, FSM in IDLE, both sync flops and debounced levels 0, all counters 0, pending requests cleared. Asserting rst mid-command drops E, S and R immediately.
- Synchroniser: two flip-flops per button.
- Debounce, per button:
  - While sync2 != deb, cnt increments each cycle; when sync2 == deb, cnt clears to 0.
  - When cnt == DEBOUNCE_CYCLES-1 and sync2 != deb still holds, deb <= sync2 on that edge and cnt clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes deb.
- Request: a registered rising-edge detect on deb (req_S, req_R), each a one-cycle pulse.
- Latency: a raw edge that stays stable produces its req pulse 2+DEBOUNCE_CYCLES+1 edges later.
- Arbitration, in IDLE:
  - req_S only: command SET.
  - req_R only: command RST.
  - Both in the same cycle: err pulses on the next edge, no command is issued, FSM stays in IDLE.
  - Any req while busy is discarded. Requests are not queued.
- FSM states:
  - IDLE: S=R=E=0, busy=0. Accepting a command moves to SETUP.
  - SETUP (1 cycle): S=1 for SET or R=1 for RST, E=0. Go to ENABLE.
  - ENABLE (PULSE_CYCLES cycles, counted by pcnt): S/R held, E=1. Go to HOLD when pcnt == PULSE_CYCLES-1.
  - HOLD (1 cycle): S/R held, E=0. Go to CHECK.
  - CHECK (1 cycle): S=R=E=0. done=1; mismatch=1 if Q_fb != (cmd==SET). Go to IDLE.
- Outputs: S, R and E are registered, with no combinational path from btn_* or Q_fb. done, mismatch and err are registered pulses.
- Invariants:
  - S&R is never 1.
  - E=1 only in ENABLE.
  - S and R are stable whenever E=1, and across its rising and falling edges.
- Command length: total busy time is PULSE_CYCLES+3 cycles (SETUP + ENABLE + HOLD + CHECK).
- Q_fb is sampled only in CHECK; its value in every other state is ignored.

Test Plan:
- Reset, then press btn_S cleanly (held 10 cycles) with the latch model attached -> req_S 7 edges after the press; SETUP, then E=1 for exactly 2 cycles with S=1 and R=0; done=1 and mismatch=0 in CHECK; Q=1.
- Press btn_R after a SET -> R=1 and S=0 throughout, E high 2 cycles, Q=0, done pulses once, busy high for exactly 5 cycles.
- btn_S glitch of 3 cycles, then low -> deb_S stays 0, no req, S/R/E remain 0.
- btn_S and btn_R rise on the same cycle and both stay stable -> err pulses once, S=R=E=0 throughout, busy stays 0.
- Press btn_R while a SET is in ENABLE -> the R request is discarded, the SET completes normally, and no second command follows. Separately, assert rst during ENABLE -> E, S, R and busy go to 0 asynchronously.
- Force Q_fb=0 during a SET -> done and mismatch both pulse in CHECK. Scoreboard the invariant S&R=0 and E only in ENABLE on every cycle of every test.
